// File: rtl/fpu_sequencer_if.sv
// fpu_sequencer_if: request/response handshake bundle for fpu_sequencer.
// Master issues requests and consumes responses; slave is the sequencer.
interface fpu_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [4:0]  req_tag;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic [4:0]  resp_tag;
    logic        resp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_tag, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag, resp_ready,
        output req_ready, resp_valid, resp_data, resp_tag, resp_err
    );
endinterface

// File: rtl/fpu_sequencer.sv
// fpu_sequencer: issues one op at a time to a combinational FPU and waits
// a per-op latency before returning the result. Optional macro: FPU_SEQ_FLUSH_EN.
module fpu_sequencer #(
    parameter int LAT_ADD  = 3,
    parameter int LAT_MUL  = 4,
    parameter int LAT_DIV  = 20,
    parameter int LAT_SQRT = 24,
    parameter int LAT_CVT  = 2,
    parameter int LAT_MV   = 1
) (
    input  logic        clk,
    input  logic        rst,
`ifdef FPU_SEQ_FLUSH_EN
    input  logic        flush,
`endif
    fpu_sequencer_if.slave bus,
    output logic [63:0] fpu_in1,
    output logic [63:0] fpu_in2,
    output logic [4:0]  fpu_op,
    input  logic [63:0] fpu_out,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cnt;
    logic       accept;
    logic       op_ok;
    logic       flush_hit;

`ifdef FPU_SEQ_FLUSH_EN
    assign flush_hit = flush;
`else
    assign flush_hit = 1'b0;
`endif

    assign accept = (state == IDLE) && bus.req_valid;
    assign op_ok  = (bus.req_op <= 5'd8);

    // Counter preload: the execute phase lasts exactly LAT cycles.
    function automatic logic [7:0] lat_m1(input logic [4:0] op);
        case (op)
            5'd0, 5'd1: return 8'(LAT_ADD - 1);
            5'd2:       return 8'(LAT_MUL - 1);
            5'd3:       return 8'(LAT_DIV - 1);
            5'd4:       return 8'(LAT_SQRT - 1);
            5'd5, 5'd6: return 8'(LAT_CVT - 1);
            default:    return 8'(LAT_MV - 1);
        endcase
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_nxt      = state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        busy           = 1'b1;
        unique case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                busy          = 1'b0;
                if (bus.req_valid)
                    state_nxt = op_ok ? EXEC : DONE;
            end
            EXEC: begin
                if (flush_hit)      state_nxt = IDLE;
                else if (cnt == 0)  state_nxt = DONE;
            end
            DONE: begin
                bus.resp_valid = 1'b1;
                if (flush_hit || bus.resp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand, counter and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpu_in1       <= '0;
            fpu_in2       <= '0;
            fpu_op        <= '0;
            cnt           <= '0;
            bus.resp_data <= '0;
            bus.resp_tag  <= '0;
            bus.resp_err  <= 1'b0;
        end else if (accept) begin
            bus.resp_tag <= bus.req_tag;
            if (op_ok) begin
                fpu_in1 <= bus.req_a;
                fpu_in2 <= bus.req_b;
                fpu_op  <= bus.req_op;
                cnt     <= lat_m1(bus.req_op);
            end else begin
                bus.resp_data <= '0;
                bus.resp_err  <= 1'b1;
            end
        end else if (state == EXEC && !flush_hit) begin
            if (cnt != 0) begin
                cnt <= cnt - 8'd1;
            end else begin
                bus.resp_data <= fpu_out;
                bus.resp_err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fpu_sequencer.sv
// tb_fpu_sequencer: directed vector table, reset/flush corner cases and
// randomized transactions against a behavioural latency/result model.
module tb_fpu_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fpu_sequencer_if bus();
    logic [63:0] fpu_in1;
    logic [63:0] fpu_in2;
    logic [63:0] fpu_out;
    logic [4:0]  fpu_op;
    logic        busy;
`ifdef FPU_SEQ_FLUSH_EN
    logic        flush = 1'b0;
`endif

    fpu_sequencer dut (
        .clk     (clk),
        .rst     (rst),
`ifdef FPU_SEQ_FLUSH_EN
        .flush   (flush),
`endif
        .bus     (bus),
        .fpu_in1 (fpu_in1),
        .fpu_in2 (fpu_in2),
        .fpu_op  (fpu_op),
        .fpu_out (fpu_out),
        .busy    (busy)
    );

    // Stand-in combinational FPU.
    function automatic logic [63:0] fpu_model(input logic [4:0] op,
                                              input logic [63:0] a,
                                              input logic [63:0] b);
        case (op)
            5'd0:       return $realtobits($bitstoreal(a) + $bitstoreal(b));
            5'd1:       return a - b;
            5'd2:       return a * b;
            5'd3:       return a ^ {b[31:0], b[63:32]};
            5'd4:       return ~a;
            5'd5:       return {a[31:0], a[63:32]};
            5'd6:       return a + 64'd1;
            5'd7, 5'd8: return a;
            default:    return 64'hBAD0BAD0BAD0BAD0;
        endcase
    endfunction

    assign fpu_out = fpu_model(fpu_op, fpu_in1, fpu_in2);

    int lat_tab[9] = '{3, 3, 4, 20, 24, 2, 2, 1, 1};

    // Cycles from accept to first resp_valid.
    function automatic int ref_lat(input logic [4:0] op);
        return (op <= 5'd8) ? lat_tab[op] + 1 : 1;
    endfunction

    int n_chk  = 0;
    int n_fail = 0;

    // Operands the FPU should currently be holding.
    logic [63:0] last_a  = '0;
    logic [63:0] last_b  = '0;
    logic [4:0]  last_op = '0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [4:0] op, input logic [63:0] a,
                             input logic [63:0] b, input logic [4:0] tag);
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_tag   = tag;
        bus.req_valid = 1'b1;
    endtask

    // One full transaction; entered and left #1 after a rising edge in IDLE.
    task automatic run_txn(input logic [4:0] op, input logic [63:0] a,
                           input logic [63:0] b, input logic [4:0] tag,
                           input int hold, input int exp_lat,
                           input logic [63:0] exp_data, input logic exp_err,
                           input bit stray);
        int n;
        chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
        drive_req(op, a, b, tag);
        tick();
        bus.req_valid = 1'b0;
        if (op <= 5'd8) begin
            last_op = op;
            last_a  = a;
            last_b  = b;
        end
        chk("fpu_op_issue", 64'(fpu_op), 64'(last_op));
        chk("fpu_in1_issue", fpu_in1, last_a);
        chk("fpu_in2_issue", fpu_in2, last_b);
        n = 1;
        while (!bus.resp_valid && n < 300) begin
            chk("req_ready_exec", 64'(bus.req_ready), 64'd0);
            if (stray) begin
                bus.req_valid = 1'($urandom_range(0, 1));
                bus.req_tag   = 5'($urandom);
                bus.req_a     = {$urandom, $urandom};
                bus.req_op    = 5'($urandom);
            end
            tick();
            n++;
        end
        bus.req_valid = 1'b0;
        chk("resp_latency", 64'(n), 64'(exp_lat));
        chk("resp_data", bus.resp_data, exp_data);
        chk("resp_tag", 64'(bus.resp_tag), 64'(tag));
        chk("resp_err", 64'(bus.resp_err), 64'(exp_err));
        chk("busy_done", 64'(busy), 64'd1);
        for (int i = 0; i < hold; i++) begin
            if (stray) bus.req_valid = 1'($urandom_range(0, 1));
            tick();
            bus.req_valid = 1'b0;
            chk("hold_valid", 64'(bus.resp_valid), 64'd1);
            chk("hold_data", bus.resp_data, exp_data);
            chk("hold_tag", 64'(bus.resp_tag), 64'(tag));
            chk("hold_err", 64'(bus.resp_err), 64'(exp_err));
            chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
        end
        bus.resp_ready = 1'b1;
        chk("hs_req_ready", 64'(bus.req_ready), 64'd0);
        tick();
        bus.resp_ready = 1'b0;
        chk("post_hs_valid", 64'(bus.resp_valid), 64'd0);
        chk("post_hs_req_ready", 64'(bus.req_ready), 64'd1);
        chk("post_hs_busy", 64'(busy), 64'd0);
        chk("idle_fpu_op_held", 64'(fpu_op), 64'(last_op));
        chk("idle_fpu_in1_held", fpu_in1, last_a);
    endtask

    // Checks the post-reset state of every output.
    task automatic chk_reset_state(input string nm);
        chk({nm, "_req_ready"}, 64'(bus.req_ready), 64'd1);
        chk({nm, "_busy"}, 64'(busy), 64'd0);
        chk({nm, "_resp_valid"}, 64'(bus.resp_valid), 64'd0);
        chk({nm, "_resp_data"}, bus.resp_data, 64'd0);
        chk({nm, "_resp_tag"}, 64'(bus.resp_tag), 64'd0);
        chk({nm, "_resp_err"}, 64'(bus.resp_err), 64'd0);
        chk({nm, "_fpu_in1"}, fpu_in1, 64'd0);
        chk({nm, "_fpu_in2"}, fpu_in2, 64'd0);
        chk({nm, "_fpu_op"}, 64'(fpu_op), 64'd0);
        last_op = '0;
        last_a  = '0;
        last_b  = '0;
    endtask

    // Accept op at T, assert rst during cycle T+k, expect a clean IDLE.
    task automatic reset_at(input logic [4:0] op, input int k);
        int n;
        bit seen;
        drive_req(op, 64'h0123456789ABCDEF, 64'h0FEDCBA987654321, 5'd19);
        tick();
        bus.req_valid = 1'b0;
        n = 1;
        while (n < k) begin
            tick();
            n++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_state($sformatf("rst_op%0d_t%0d", op, k));
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (bus.resp_valid) seen = 1'b1;
        end
        chk("no_resp_after_rst", 64'(seen), 64'd0);
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  tag;
        int          hold;
        int          exp_lat;
        logic [63:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vt[11];

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_op     = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_tag    = '0;
        bus.resp_ready = 1'b0;

        vt[0]  = '{5'd0,  64'h3FF0000000000000, 64'h4000000000000000,
                   5'd7,  0, 4,  64'h4008000000000000, 1'b0};
        vt[1]  = '{5'd3,  64'h00000000000000FF, 64'h0000000100000000,
                   5'd12, 5, 21, 64'h00000000000000FE, 1'b0};
        vt[2]  = '{5'd7,  64'hDEADBEEFCAFEF00D, 64'h1111111111111111,
                   5'd3,  0, 2,  64'hDEADBEEFCAFEF00D, 1'b0};
        vt[3]  = '{5'd9,  64'h5555555555555555, 64'hAAAAAAAAAAAAAAAA,
                   5'd9,  2, 1,  64'h0,                1'b1};
        vt[4]  = '{5'd2,  64'd3,                64'd5,
                   5'd1,  1, 5,  64'd15,               1'b0};
        vt[5]  = '{5'd1,  64'd10,               64'd3,
                   5'd31, 0, 4,  64'd7,                1'b0};
        vt[6]  = '{5'd4,  64'h0,                64'h0,
                   5'd0,  0, 25, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        vt[7]  = '{5'd5,  64'h1122334455667788, 64'h0,
                   5'd17, 0, 3,  64'h5566778811223344, 1'b0};
        vt[8]  = '{5'd6,  64'd41,               64'd0,
                   5'd22, 1, 3,  64'd42,               1'b0};
        vt[9]  = '{5'd8,  64'h123,              64'h456,
                   5'd4,  0, 2,  64'h123,              1'b0};
        vt[10] = '{5'd31, 64'h1,                64'h2,
                   5'd30, 0, 1,  64'h0,                1'b1};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_state("por");

        for (int i = 0; i < 11; i++)
            run_txn(vt[i].op, vt[i].a, vt[i].b, vt[i].tag, vt[i].hold,
                    vt[i].exp_lat, vt[i].exp_data, vt[i].exp_err, 1'b0);

        reset_at(5'd4, 10);
        reset_at(5'd3, 21);
        reset_at(5'd9, 1);

`ifdef FPU_SEQ_FLUSH_EN
        begin
            int  n;
            bit  seen;
            flush = 1'b1;
            tick();
            flush = 1'b0;
            chk("flush_idle_ready", 64'(bus.req_ready), 64'd1);
            drive_req(5'd3, 64'h77, 64'h88, 5'd5);
            tick();
            bus.req_valid = 1'b0;
            last_op = 5'd3;
            last_a  = 64'h77;
            last_b  = 64'h88;
            n = 1;
            while (n < 5) begin
                tick();
                n++;
            end
            flush = 1'b1;
            tick();
            flush = 1'b0;
            chk("flush_req_ready", 64'(bus.req_ready), 64'd1);
            chk("flush_busy", 64'(busy), 64'd0);
            seen = 1'b0;
            repeat (30) begin
                tick();
                if (bus.resp_valid) seen = 1'b1;
            end
            chk("flush_no_resp", 64'(seen), 64'd0);
            drive_req(5'd9, 64'h0, 64'h0, 5'd2);
            tick();
            bus.req_valid = 1'b0;
            chk("flush_done_valid", 64'(bus.resp_valid), 64'd1);
            flush = 1'b1;
            tick();
            flush = 1'b0;
            chk("flush_done_idle", 64'(bus.req_ready), 64'd1);
            chk("flush_done_novalid", 64'(bus.resp_valid), 64'd0);
        end
`endif

        for (int i = 0; i < 40; i++) begin
            logic [4:0]  op;
            logic [63:0] a;
            logic [63:0] b;
            logic [4:0]  tag;
            op  = ($urandom_range(0, 9) < 8) ? 5'($urandom_range(0, 8))
                                             : 5'($urandom_range(9, 31));
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            tag = 5'($urandom);
            run_txn(op, a, b, tag, $urandom_range(0, 3), ref_lat(op),
                    (op <= 5'd8) ? fpu_model(op, a, b) : 64'd0,
                    (op > 5'd8), 1'b1);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
